paddle_input_ctrl: RTL and testbench
====================================

// Module: paddle_input_ctrl
// PURPOSE
//  Sequences the player's debounced key inputs (left, right, launch) into discrete paddle/ball
//  commands for the game core. Adds per-key edge detection, left/right arbitration and optional
//  hold-to-repeat. Delivers one command at a time over a valid/ready handshake. Sits between the
//  synchronised KEY inputs and the paddle/ball update logic.
// PARAMETERS
//  CNT_W         8   width of repeat counter
//  REPEAT_DELAY  16  cycles a direction key is held before the first repeat (1..2^CNT_W-1)
//  REPEAT_PERIOD 4   cycles between subsequent repeats (1..2^CNT_W-1)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  key_left    in   1  left key level, already synchronised, 1 = pressed
//  key_right   in   1  right key level, 1 = pressed
//  key_launch  in   1  launch key level, 1 = pressed
//  game_run    in   1  1 = move commands permitted; launch always permitted
//  cmd_ready   in   1  game core accepts cmd this cycle
//  cmd_valid   out  1  command pending
//  cmd_op      out  2  01 = move left, 10 = move right, 11 = launch, 00 only when !cmd_valid
//  dropped     out  1  one-cycle pulse: an event was discarded
// BEHAVIOUR
//  - Reset (reset=0, async): FSM=IDLE, counter=0, launch edge reg=0, cmd_valid=0, cmd_op=00,
//    dropped=0. Mid-operation reset clears any pending cmd immediately; no cmd survives.
//  - Launch event: key_launch=1 while prior-cycle key_launch=0 (one event per press).
//  - Direction FSM (registered, updates every cycle):
//    IDLE : L&!R -> LEFT (move-left event); R&!L -> RIGHT (move-right event); L&R -> LOCK.
//    LEFT : !L&!R -> IDLE; !L&R -> RIGHT (move-right event); L&R -> LOCK; L&!R stay.
//    RIGHT: mirror of LEFT.
//    LOCK : no events; -> IDLE only when L=0 and R=0.
//  - Counter: cleared on every FSM transition; increments while in LEFT/RIGHT, saturating at
//    2^CNT_W-1.
//  - Event generation: an event is generated in the same cycle the key level is sampled. It is
//    registered into cmd on the following edge: latency 1 cycle key->cmd_valid.
//  - Move events are suppressed (not dropped, no pulse) while game_run=0. FSM still tracks keys.
//  - Handshake: cmd_valid/cmd_op are held stable until a cycle with cmd_valid&cmd_ready.
//    On that cycle the cmd clears, unless a new event loads in the same cycle (back-to-back allowed).
//  - Event arriving while cmd_valid&!cmd_ready: event discarded, dropped=1 for one cycle.
//  - Simultaneous launch + move event in one cycle: launch wins, move discarded, dropped=1.
//  - cmd_op bit widths exact; counter compares use CNT_W-bit unsigned arithmetic.
// CONFIGURATION
//  PADDLE_AUTOREPEAT_EN defined:
//    - In LEFT/RIGHT, a repeat move event fires when counter==REPEAT_DELAY-1.
//    - Thereafter a repeat fires every REPEAT_PERIOD cycles while the key is held; the counter
//      reloads to REPEAT_DELAY-REPEAT_PERIOD after each repeat.
//    - Repeats obey game_run, the handshake and drop rules.
//  PADDLE_AUTOREPEAT_EN undefined:
//    - Exactly one move event per entry into LEFT/RIGHT; no repeats.
//    - Counter logic is omitted and the CNT_W/REPEAT_* parameters are unused.
// TESTING
//  1. reset=0 with key_left=1 for 3 cycles, then release -> cmd_valid=0, cmd_op=00 throughout;
//     next cycle left edge -> cmd_valid=1, cmd_op=01.
//  2. game_run=1, cmd_ready=1, key_left held 3 cycles (no autorepeat) -> exactly one cmd 01,
//     valid for 1 cycle, dropped never set.
//  3. key_left=1 then key_right=1 (both held) -> one cmd 01, then LOCK, no cmd.
//     Release right only -> still no cmd. Release both, press right -> cmd 10.
//  4. cmd_ready=0, press launch then press left -> cmd_op=11 held stable, dropped pulse on left
//     event; cmd_ready=1 -> cmd accepted, cmd_valid=0 next cycle.
//  5. Same-cycle launch edge + right edge -> cmd_op=11, dropped=1.
//     game_run=0 + left press -> no cmd, dropped=0.
//  6. PADDLE_AUTOREPEAT_EN, DELAY=16, PERIOD=4, cmd_ready=1, key_left held 30 cycles -> cmd 01
//     at cycles 1, 17, 21, 25, 29 after press; assert reset mid-hold -> cmd_valid=0 immediately.

Source files
------------

// File: rtl/paddle_input_ctrl.sv
// Paddle input controller: turns key levels into one-at-a-time move/launch commands.
// Optional hold-to-repeat is enabled by defining PADDLE_AUTOREPEAT_EN.
module paddle_input_ctrl #(
  parameter int CNT_W         = 8,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_launch,
  input  logic       game_run,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic       dropped,
  output logic [1:0] dbg_state
);

  // Handshake: a command is presented while cmd_valid=1 and cmd_op is held stable
  // until a cycle with cmd_valid & cmd_ready; a new event may load in that same cycle.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_LEFT   = 2'b01;
  localparam logic [1:0] OP_RIGHT  = 2'b10;
  localparam logic [1:0] OP_LAUNCH = 2'b11;

  state_t state, state_nxt;
  logic   launch_q;
  logic   ev_left, ev_right;
  logic   rep_fire;
  logic   launch_ev, move_ev, can_load;
  logic [1:0] move_op;

`ifdef PADDLE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_M1 = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] cnt;

  assign rep_fire = (cnt == DELAY_M1);

  // Reloading below DELAY_M1 after each repeat yields the shorter repeat period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == ST_LEFT || state == ST_RIGHT) begin
      if (rep_fire)
        cnt <= RELOAD;
      else if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ev_left   = 1'b0;
    ev_right  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_left && !key_right) begin
          state_nxt = ST_LEFT;
          ev_left   = 1'b1;
        end else if (key_right && !key_left) begin
          state_nxt = ST_RIGHT;
          ev_right  = 1'b1;
        end else if (key_left && key_right) begin
          state_nxt = ST_LOCK;
        end
      end
      ST_LEFT: begin
        if (!key_left && !key_right) begin
          state_nxt = ST_IDLE;
        end else if (!key_left && key_right) begin
          state_nxt = ST_RIGHT;
          ev_right  = 1'b1;
        end else if (key_left && key_right) begin
          state_nxt = ST_LOCK;
        end else begin
          ev_left = rep_fire;
        end
      end
      ST_RIGHT: begin
        if (!key_left && !key_right) begin
          state_nxt = ST_IDLE;
        end else if (key_left && !key_right) begin
          state_nxt = ST_LEFT;
          ev_left   = 1'b1;
        end else if (key_left && key_right) begin
          state_nxt = ST_LOCK;
        end else begin
          ev_right = rep_fire;
        end
      end
      default: begin
        if (!key_left && !key_right)
          state_nxt = ST_IDLE;
      end
    endcase
  end

  assign launch_ev = key_launch && !launch_q;
  // Move events are suppressed, not dropped, while the game is not running.
  assign move_ev   = (ev_left || ev_right) && game_run;
  assign move_op   = ev_left ? OP_LEFT : OP_RIGHT;
  assign can_load  = !cmd_valid || cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      launch_q  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_NONE;
      dropped   <= 1'b0;
    end else begin
      launch_q <= key_launch;
      dropped  <= (launch_ev && move_ev) || (!can_load && (launch_ev || move_ev));
      if (can_load && launch_ev) begin
        cmd_valid <= 1'b1;
        cmd_op    <= OP_LAUNCH;
      end else if (can_load && move_ev) begin
        cmd_valid <= 1'b1;
        cmd_op    <= move_op;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        cmd_op    <= OP_NONE;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed-vector bench for paddle_input_ctrl: expected commands and drop pulses are
// queued with the cycle they must appear in; a negedge monitor pops and compares.
module tb_paddle_input_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_left, key_right, key_launch, game_run, cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       dropped;
  logic [1:0] dbg_state;

  logic [31:0] cyc = '0;
  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];
  logic [31:0] drop_q[$];

`ifdef PADDLE_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  paddle_input_ctrl #(.CNT_W(8), .REPEAT_DELAY(16), .REPEAT_PERIOD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_launch (key_launch),
    .game_run   (game_run),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .dropped    (dropped),
    .dbg_state  (dbg_state)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs; op/drp are the hand-computed results visible next cycle.
  task automatic step(input logic l, input logic r, input logic la, input logic run,
                      input logic rdy, input logic [1:0] op, input logic drp);
    key_left   = l;
    key_right  = r;
    key_launch = la;
    game_run   = run;
    cmd_ready  = rdy;
    if (op != 2'b00) exp_q.push_back({cyc + 32'd1, op});
    if (drp) drop_q.push_back(cyc + 32'd1);
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  logic       prev_hold = 1'b0;
  logic [1:0] prev_op   = 2'b00;
  always @(negedge clk) begin
    if (reset) begin
      if (!cmd_valid) check("op_zero_when_idle", {32'd0, cmd_op}, 34'd0);
      if (prev_hold) begin
        check("hold_stable", {31'd0, cmd_valid, cmd_op}, {31'd0, 1'b1, prev_op});
      end else if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {32'd0, cmd_op}, 34'd0);
        end else begin
          check("cmd_cycle_op", {cyc, cmd_op}, exp_q.pop_front());
        end
      end
      if (dropped) begin
        if (drop_q.size() == 0)
          check("unexpected_drop", 34'd1, 34'd0);
        else
          check("drop_cycle", {2'b00, cyc}, {2'b00, drop_q.pop_front()});
      end
      prev_hold = cmd_valid && !cmd_ready;
      prev_op   = cmd_op;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    key_left   = 1'b1;
    key_right  = 1'b0;
    key_launch = 1'b0;
    game_run   = 1'b1;
    cmd_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {33'd0, cmd_valid}, 34'd0);
    check("rst_op", {32'd0, cmd_op}, 34'd0);
    check("rst_dropped", {33'd0, dropped}, 34'd0);
    check("rst_state", {32'd0, dbg_state}, 34'd0);

    // left held through reset release: command one cycle later
    reset = 1'b1;
    step(1, 0, 0, 1, 1, 2'b01, 0);
    step(1, 0, 0, 1, 1, 2'b00, 0);
    step(1, 0, 0, 1, 1, 2'b00, 0);
    step(0, 0, 0, 1, 1, 2'b00, 0);

    // left then both -> LOCK; release right only stays locked; then right
    step(1, 0, 0, 1, 1, 2'b01, 0);
    step(1, 1, 0, 1, 1, 2'b00, 0);
    check("lock_state", {32'd0, dbg_state}, 34'd3);
    step(1, 0, 0, 1, 1, 2'b00, 0);
    step(0, 0, 0, 1, 1, 2'b00, 0);
    step(0, 1, 0, 1, 1, 2'b10, 0);
    step(0, 0, 0, 1, 1, 2'b00, 0);

    // stalled launch, left event dropped, then accepted
    step(0, 0, 1, 1, 0, 2'b11, 0);
    step(1, 0, 1, 1, 0, 2'b00, 1);
    step(1, 0, 1, 1, 0, 2'b00, 0);
    step(0, 0, 0, 1, 1, 2'b00, 0);

    // same-cycle launch + right: launch wins, move dropped
    step(0, 1, 1, 1, 1, 2'b11, 1);
    step(0, 0, 0, 1, 1, 2'b00, 0);

    // game_run=0 suppresses moves silently
    step(1, 0, 0, 0, 1, 2'b00, 0);
    step(1, 0, 0, 0, 1, 2'b00, 0);
    step(0, 0, 0, 0, 1, 2'b00, 0);

    // back-to-back loads on accept cycles
    step(1, 0, 0, 1, 1, 2'b01, 0);
    step(0, 1, 0, 1, 1, 2'b10, 0);
    step(0, 0, 1, 1, 1, 2'b11, 0);
    step(0, 0, 0, 1, 1, 2'b00, 0);

    // launch allowed while game_run=0; suppressed move during stall is not a drop
    step(0, 0, 1, 0, 0, 2'b11, 0);
    step(1, 0, 1, 0, 0, 2'b00, 0);
    step(0, 0, 0, 0, 1, 2'b00, 0);
    step(0, 0, 0, 1, 1, 2'b00, 0);

    // 30-cycle hold: repeats at 17, 21, 25, 29 only with autorepeat
    step(1, 0, 0, 1, 1, 2'b01, 0);
    for (int i = 1; i < 30; i++) begin
      if (AUTO && i >= 16 && ((i - 16) % 4) == 0)
        step(1, 0, 0, 1, 1, 2'b01, 0);
      else
        step(1, 0, 0, 1, 1, 2'b00, 0);
    end

    // park a launch command, then reset mid-hold must clear it at once
    step(1, 0, 1, 1, 0, 2'b11, 0);
    step(1, 0, 1, 1, 0, 2'b00, 0);
    reset = 1'b0;
    #1;
    check("midrst_valid", {33'd0, cmd_valid}, 34'd0);
    check("midrst_op", {32'd0, cmd_op}, 34'd0);
    check("midrst_state", {32'd0, dbg_state}, 34'd0);
    key_left   = 1'b0;
    key_launch = 1'b0;
    cmd_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 0, 0, 1, 1, 2'b00, 0);
    step(0, 0, 0, 1, 1, 2'b00, 0);

    check("exp_q_empty", 34'(exp_q.size()), 34'd0);
    check("drop_q_empty", 34'(drop_q.size()), 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
